// File: rtl/mem_1w1r_param.sv
// Single-clock, one-write/one-read memory with byte enables, a reset-triggered zero-fill sweep,
// 1- or 2-cycle pipelined reads, optional write-to-read bypass and out-of-range access flagging.
module mem_1w1r_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int PTR_WIDTH      = 4,
  parameter int DEPTH          = 16,
  parameter int RD_LATENCY     = 1,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PTR_WIDTH-1:0]    waddr,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [PTR_WIDTH-1:0]    raddr,
  input  logic                    ren,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    init_busy,
  output logic                    addr_err
);

  localparam int                   BYTES     = DATA_WIDTH / 8;
  localparam logic [PTR_WIDTH:0]   DEPTH_EXT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
  localparam bit                   CLR_EN    = (CLEAR_ON_RESET != 0);
  localparam bit                   BYP_EN    = (BYPASS != 0);

  generate
    if ((DATA_WIDTH % 8) != 0 || DEPTH < 1 || DEPTH > (2 ** PTR_WIDTH) ||
        (RD_LATENCY != 1 && RD_LATENCY != 2)) begin : g_bad_params
      $error("mem_1w1r_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                 state;
  logic [PTR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   idle;
  logic                   clr_we;
  logic                   wr_in_range;
  logic                   rd_in_range;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   err_p0;
  logic [DATA_WIDTH-1:0]  rd_word_p0;
  logic                   vld_last;
  logic [DATA_WIDTH-1:0]  word_last;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // A cycle with rst high never counts as an accepted access.
  assign idle        = (state == IDLE) && !rst;
  assign clr_we      = (state == CLEAR) && !rst;
  assign wr_in_range = {1'b0, waddr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, raddr} < DEPTH_EXT;
  assign wr_acc      = idle && wen && wr_in_range;
  assign rd_acc      = idle && ren;
  assign err_p0      = idle && ((wen && !wr_in_range) || (ren && !rd_in_range));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLR_EN ? CLEAR : IDLE;
      clr_ptr   <= '0;
      init_busy <= CLR_EN;
    end else if (state == CLEAR) begin
      if (clr_ptr == LAST_PTR) begin
        state     <= IDLE;
        init_busy <= 1'b0;
        clr_ptr   <= '0;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Stage p0: array lookup at acceptance, with optional same-address write forwarding.
  always_comb begin
    rd_word_p0 = '0;
    if (rd_in_range) begin
      rd_word_p0 = mem[raddr];
      if (BYP_EN && wr_acc && (waddr == raddr)) begin
        rd_word_p0 = byte_merge(mem[raddr], wdata, wbe);
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rd_word_p1;

      // Stage p1: extra register slice for the two-cycle read path.
      always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= rd_acc;
      end

      always_ff @(posedge clk) begin
        if (rd_acc) rd_word_p1 <= rd_word_p0;
      end

      assign vld_last  = vld_p1;
      assign word_last = rd_word_p1;
    end else begin : g_lat1
      assign vld_last  = rd_acc;
      assign word_last = rd_word_p0;
    end
  endgenerate

  // Output stage: rdata only moves when a result is delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= vld_last;
      addr_err <= err_p0;
      if (vld_last) rdata <= word_last;
    end
  end

endmodule

// File: tb/tb_mem_1w1r_param.sv
// Bench for mem_1w1r_param: two configurations driven in lockstep (defaults, and DEPTH=12 /
// RD_LATENCY=2 / BYPASS=1), checked against a per-configuration array-and-queue reference.
module tb_mem_1w1r_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  waddr;
  logic        wen;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic [3:0]  raddr;
  logic        ren;

  logic [31:0] rd_o   [2];
  logic        rv_o   [2];
  logic        busy_o [2];
  logic        err_o  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_1w1r_param #(
    .DATA_WIDTH(32), .PTR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst), .waddr(waddr), .wen(wen), .wbe(wbe), .wdata(wdata),
    .raddr(raddr), .ren(ren), .rdata(rd_o[0]), .rvalid(rv_o[0]),
    .init_busy(busy_o[0]), .addr_err(err_o[0])
  );

  mem_1w1r_param #(
    .DATA_WIDTH(32), .PTR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2), .BYPASS(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst), .waddr(waddr), .wen(wen), .wbe(wbe), .wdata(wdata),
    .raddr(raddr), .ren(ren), .rdata(rd_o[1]), .rvalid(rv_o[1]),
    .init_busy(busy_o[1]), .addr_err(err_o[1])
  );

  // Reference model state
  typedef struct {
    int          c;
    int          due;
    logic [31:0] d;
  } rd_t;

  int          dep [2] = '{16, 12};
  int          lat [2] = '{1, 2};
  bit          byp [2] = '{1'b0, 1'b1};
  logic [31:0] mm  [2][16];
  int          left[2];
  logic        exp_rv [2];
  logic        exp_err[2];
  logic [31:0] exp_rd [2];
  rd_t         q[$];
  int          cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
    wen = we; waddr = wa; wbe = be; wdata = wd; ren = re; raddr = ra;
  endtask

  // One clock edge: evaluate the access rules on the current inputs, advance the model.
  task automatic tick();
    logic        r;
    logic        idl;
    logic        acc_w[2];
    logic        acc_r[2];
    logic        er[2];
    logic [31:0] rv[2];
    r = rst;
    for (int c = 0; c < 2; c++) begin
      idl      = (left[c] == 0) && !r;
      acc_w[c] = idl && wen && (int'(waddr) < dep[c]);
      acc_r[c] = idl && ren;
      er[c]    = idl && ((wen && int'(waddr) >= dep[c]) || (ren && int'(raddr) >= dep[c]));
      rv[c]    = 32'h0;
      if (int'(raddr) < dep[c]) begin
        rv[c] = mm[c][raddr];
        if (byp[c] && acc_w[c] && waddr == raddr) rv[c] = merge(rv[c], wdata, wbe);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      q.delete();
      for (int c = 0; c < 2; c++) begin
        left[c] = dep[c]; exp_rd[c] = 32'h0; exp_rv[c] = 1'b0; exp_err[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (left[c] > 0) begin
          left[c]--;
          if (left[c] == 0) for (int i = 0; i < 16; i++) mm[c][i] = 32'h0;
        end
        if (acc_w[c]) mm[c][waddr] = merge(mm[c][waddr], wdata, wbe);
        if (acc_r[c]) q.push_back('{c, cyc + lat[c] - 1, rv[c]});
        exp_err[c] = er[c];
        exp_rv[c]  = 1'b0;
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) begin
          exp_rv[q[i].c] = 1'b1;
          exp_rd[q[i].c] = q[i].d;
          q.delete(i);
        end
      end
    end
  endtask

  task automatic test_reset();
    int n[2];
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({rd_o[c], rv_o[c], err_o[c], busy_o[c]} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL reset_state c=%0d got rd=%h rv=%0b err=%0b busy=%0b want 0/0/0/1",
                 c, rd_o[c], rv_o[c], err_o[c], busy_o[c]);
      end
    end
    rst = 1'b0;
    n = '{0, 0};
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < 2; c++) if (busy_o[c] === 1'b1) n[c]++;
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (n[c] != dep[c]) begin
        bad++;
        $display("FAIL sweep_len c=%0d got %0d cycles want %0d", c, n[c], dep[c]);
      end
    end
  endtask

  task automatic test_clear_reads();
    for (int a = 0; a <= 16; a++) begin
      if (a < 16) drive(0, 0, 0, 0, 1, 4'(a));
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (a < 16) begin
        total++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 32'h0) begin
          bad++;
          $display("FAIL clear_read_a addr=%0d got rv=%0b rd=%h want rv=1 rd=0", a, rv_o[0], rd_o[0]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        total++;
        if ({rv_o[c], rd_o[c], err_o[c]} !== {exp_rv[c], exp_rd[c], exp_err[c]}) begin
          bad++;
          $display("FAIL clear_read_model c=%0d cyc=%0d got rv=%0b rd=%h err=%0b want rv=%0b rd=%h err=%0b",
                   c, cyc, rv_o[c], rd_o[c], err_o[c], exp_rv[c], exp_rd[c], exp_err[c]);
        end
      end
    end
    tick();
  endtask

  task automatic test_byte_enables();
    drive(1, 4'd3, 4'hF, 32'hAABBCCDD, 0, 0);
    tick();
    drive(1, 4'd3, 4'b0101, 32'h11223344, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 4'd3);
    tick();
    total++;
    if (rv_o[0] !== 1'b1 || rd_o[0] !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL byte_en_a got rv=%0b rd=%h want rv=1 rd=aa22cc44", rv_o[0], rd_o[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (rv_o[1] !== 1'b1 || rd_o[1] !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL byte_en_b got rv=%0b rd=%h want rv=1 rd=aa22cc44", rv_o[1], rd_o[1]);
    end
  endtask

  task automatic test_rdw();
    drive(1, 4'd5, 4'hF, 32'h0, 0, 0);
    tick();
    drive(1, 4'd5, 4'hF, 32'hDEADBEEF, 1, 4'd5);
    tick();
    total++;
    if (rv_o[0] !== 1'b1 || rd_o[0] !== 32'h0) begin
      bad++;
      $display("FAIL rdw_old_a got rv=%0b rd=%h want rv=1 rd=0", rv_o[0], rd_o[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (rv_o[1] !== 1'b1 || rd_o[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rdw_new_b got rv=%0b rd=%h want rv=1 rd=deadbeef", rv_o[1], rd_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++) begin
      drive(1, 4'(a), 4'hF, 32'(a + 1), 0, 0);
      tick();
    end
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) drive(0, 0, 0, 0, 1, 4'(k - 1));
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      total++;
      if (rv_o[0] !== (k <= 4) || (k <= 4 && rd_o[0] !== 32'(k))) begin
        bad++;
        $display("FAIL b2b_a k=%0d got rv=%0b rd=%h want rv=%0b rd=%0d", k, rv_o[0], rd_o[0], k <= 4, k);
      end
      total++;
      if (rv_o[1] !== (k >= 2 && k <= 5) || (k >= 2 && k <= 5 && rd_o[1] !== 32'(k - 1))) begin
        bad++;
        $display("FAIL b2b_b k=%0d got rv=%0b rd=%h want rv=%0b rd=%0d",
                 k, rv_o[1], rd_o[1], k >= 2 && k <= 5, k - 1);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] snap[12];
    for (int i = 0; i < 12; i++) snap[i] = mm[1][i];
    drive(1, 4'd13, 4'hF, 32'h55, 0, 0);
    tick();
    total++;
    if (err_o[1] !== 1'b1 || err_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL oor_write_err got b=%0b a=%0b want b=1 a=0", err_o[1], err_o[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (err_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL oor_err_pulse got %0b want 0", err_o[1]);
    end
    drive(0, 0, 0, 0, 1, 4'd13);
    tick();
    total++;
    if (err_o[1] !== 1'b1 || rv_o[0] !== 1'b1 || rd_o[0] !== 32'h55) begin
      bad++;
      $display("FAIL oor_read_err got err_b=%0b rv_a=%0b rd_a=%h want 1/1/55", err_o[1], rv_o[0], rd_o[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (rv_o[1] !== 1'b1 || rd_o[1] !== 32'h0 || err_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL oor_read_data got rv=%0b rd=%h err=%0b want 1/0/0", rv_o[1], rd_o[1], err_o[1]);
    end
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(0, 0, 0, 0, 1, 4'(i));
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (i >= 1) begin
        total++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== snap[i - 1]) begin
          bad++;
          $display("FAIL oor_unchanged addr=%0d got rv=%0b rd=%h want rd=%h", i - 1, rv_o[1], rd_o[1], snap[i - 1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n[2];
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(1, 4'($urandom_range(0, 15)), 4'hF, 32'hFFFFFFFF, 1, 4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = '{0, 0};
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < 2; c++) if (busy_o[c] === 1'b1) n[c]++;
      if (left[0] > 0 && left[1] > 0)
        drive(1, 4'($urandom_range(0, 15)), 4'hF, 32'hFFFFFFFF, 1, 4'($urandom_range(0, 15)));
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      for (int c = 0; c < 2; c++) begin
        total++;
        if (rv_o[c] !== exp_rv[c] || err_o[c] !== exp_err[c] || busy_o[c] !== (left[c] != 0)) begin
          bad++;
          $display("FAIL sweep_ctrl c=%0d cyc=%0d got rv=%0b err=%0b busy=%0b want %0b/%0b/%0b",
                   c, cyc, rv_o[c], err_o[c], busy_o[c], exp_rv[c], exp_err[c], left[c] != 0);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (n[c] != dep[c]) begin
        bad++;
        $display("FAIL resweep_len c=%0d got %0d want %0d", c, n[c], dep[c]);
      end
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive(0, 0, 0, 0, 1, 4'(i));
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (i < 16) begin
        total++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 32'h0) begin
          bad++;
          $display("FAIL resweep_zero_a addr=%0d got rv=%0b rd=%h want 1/0", i, rv_o[0], rd_o[0]);
        end
      end
      if (i >= 1) begin
        total++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== 32'h0) begin
          bad++;
          $display("FAIL resweep_zero_b addr=%0d got rv=%0b rd=%h want 1/0", i - 1, rv_o[1], rd_o[1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] wa;
    for (int k = 0; k < 400; k++) begin
      rst = (k == 200);
      wa  = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wa, 4'($urandom), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
      tick();
      for (int c = 0; c < 2; c++) begin
        total++;
        if ({rv_o[c], rd_o[c], err_o[c], busy_o[c]} !==
            {exp_rv[c], exp_rd[c], exp_err[c], left[c] != 0}) begin
          bad++;
          $display("FAIL random c=%0d cyc=%0d got rv=%0b rd=%h err=%0b busy=%0b want rv=%0b rd=%h err=%0b busy=%0b",
                   c, cyc, rv_o[c], rd_o[c], err_o[c], busy_o[c],
                   exp_rv[c], exp_rd[c], exp_err[c], left[c] != 0);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      left[c] = 0; exp_rv[c] = 1'b0; exp_err[c] = 1'b0; exp_rd[c] = 32'h0;
      for (int i = 0; i < 16; i++) mm[c][i] = 32'h0;
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_clear_reads();
    test_byte_enables();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_1w1r_param.md
MEM_1W1R_PARAM -- requirements
Module: mem_1w1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter PTR_WIDTH, default 4: address width.
REQ-003 SHALL have parameter DEPTH, default 16: number of entries; must satisfy 1 <= DEPTH <= 2**PTR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1: ren-to-rvalid latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter BYPASS, default 0: read-during-write to the same address. 1 = new data returned; 0 = old data returned.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill all entries after reset.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 waddr  input  PTR_WIDTH  write address.
REQ-010 wen  input  1  write enable.
REQ-011 wbe  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 wdata  input  DATA_WIDTH  write data.
REQ-013 raddr  input  PTR_WIDTH  read address.
REQ-014 ren  input  1  read request.
REQ-015 rdata  output  DATA_WIDTH  registered read data.
REQ-016 rvalid  output  1  rdata carries the result of an accepted read this cycle.
REQ-017 init_busy  output  1  clear sweep in progress.
REQ-018 addr_err  output  1  one-cycle pulse for an out-of-range access.

Function
REQ-019 The FSM SHALL have two states: CLEAR and IDLE. With rst high, the next state is CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-020 In CLEAR, the FSM SHALL write all-zero to entry clr_ptr once per cycle, for clr_ptr = 0..DEPTH-1, then enter IDLE. The sweep takes exactly DEPTH cycles after rst deasserts.
REQ-021 init_busy SHALL be high exactly while in CLEAR. wen and ren SHALL be ignored in CLEAR: no write, no rvalid, no addr_err.
REQ-022 rst asserted mid-sweep SHALL restart the sweep at entry 0 after rst deasserts.
REQ-023 An IDLE write SHALL be accepted when wen=1 and waddr<DEPTH. Only bytes with wbe[i]=1 are updated. wbe=0 SHALL leave the entry unchanged.
REQ-024 An IDLE read SHALL be accepted when ren=1. rvalid SHALL assert exactly RD_LATENCY cycles after acceptance, with rdata = entry content sampled at acceptance.
REQ-025 Reads SHALL be fully pipelined: one accepted read per cycle, with no bubbles at either latency.
REQ-026 When no rvalid is issued, rdata SHALL hold its previous value.
REQ-027 For same-cycle accepted read and write to the same in-range address:
- BYPASS=1: rdata = per-byte merge (wdata where wbe=1, old data otherwise).
- BYPASS=0: rdata = old data.
REQ-028 Out-of-range write (waddr>=DEPTH) SHALL be dropped.
REQ-029 Out-of-range read (raddr>=DEPTH) SHALL still produce rvalid, with rdata = 0.
REQ-030 addr_err SHALL pulse high one cycle after any IDLE cycle with an out-of-range accepted wen or ren (either or both).
REQ-031 Memory contents SHALL be undefined after reset when CLEAR_ON_RESET=0.

Reset
REQ-032 With rst high: rdata=0, rvalid=0, addr_err=0, read pipeline flushed, clr_ptr=0, init_busy=CLEAR_ON_RESET.
REQ-033 Reset SHALL take effect on the first rising clk edge with rst high.
REQ-034 Memory contents SHALL NOT be reset by rst itself; only the CLEAR sweep zeros them.

Verification
REQ-035 Clear sweep (defaults): rst for 2 cycles, then release.
- init_busy high for exactly 16 cycles, then low.
- Read of each address 0..15 -> rdata=0, rvalid 1 cycle later.
REQ-036 Byte enables: write 0xAABBCCDD with wbe=4'hF to addr 3, then write 0x11223344 with wbe=4'b0101 to addr 3.
- Read addr 3 -> 0xAA22CC44.
REQ-037 Read-during-write: addr 5 holds 0x0; same cycle wen/ren, addr 5, wdata 0xDEADBEEF, wbe=4'hF.
- BYPASS=1 -> rdata 0xDEADBEEF.
- BYPASS=0 -> rdata 0x0.
REQ-038 Latency/throughput (RD_LATENCY=2): ren on 4 consecutive cycles, addrs 0..3 preloaded 1..4.
- rvalid high for 4 consecutive cycles, starting 2 cycles after the first ren, data 1,2,3,4.
REQ-039 Out of range (DEPTH=12): write 0x55 to addr 13, then read addr 13.
- addr_err pulses after each access; read gives rvalid with rdata=0.
- Entries 0..11 unchanged.
REQ-040 Reset mid-sweep: assert rst at sweep cycle 7 for 1 cycle.
- init_busy stays high 16 further cycles after release.
- Concurrent wen during the sweep has no effect.
